// File: rtl/cpu_pkg.sv
// Shared definitions for the pipeline hazard controller: stage indices and
// the interrupt-entry state encoding.
package cpu_pkg;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    MASKED = 2'd2
  } irq_state_t;

endpackage

// File: rtl/stall_mask_gen.sv
// Priority encoder: turns per-stage stall requests into a thermometer mask
// covering the highest requesting stage and every stage below it.
module stall_mask_gen #(
  parameter int STAGES = 6
) (
  input  logic [STAGES-1:0] stall_req,
  output logic [STAGES-1:0] stall_mask
);

  logic acc;

  always_comb begin
    acc        = 1'b0;
    stall_mask = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc           = acc | stall_req[k];
      stall_mask[k] = acc;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, jump redirect,
// interrupt-entry FSM and stall-cycle counter.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int STAGES     = 6,
  parameter int JUMP_STAGE = 3,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stall_req,
  input  logic              jump_flag,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic              irq_req,
  input  logic [ADDR_W-1:0] irq_vec,
  input  logic              irq_done,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_addr,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] irq_epc,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  irq_state_t        state_q, state_d;
  logic [STAGES-1:0] stall_mask;
  logic [STAGES-1:0] jump_flush;
  logic              blocked_hi;
  logic              jump_take;
  logic              trap_take;

  stall_mask_gen #(.STAGES(STAGES)) u_stall_mask_gen (
    .stall_req  (stall_req),
    .stall_mask (stall_mask)
  );

  // The thermometer bit at JUMP_STAGE is set exactly when some stage at or
  // above the jump stage is requesting a stall.
  assign blocked_hi = stall_mask[JUMP_STAGE];

  always_comb begin
    jump_flush = '0;
    for (int k = 1; k <= JUMP_STAGE; k++) begin
      jump_flush[k] = 1'b1;
    end
  end

  always_comb begin
    jump_take      = !rst && jump_flag && !blocked_hi;
    trap_take      = !rst && (state_q == DRAIN) && irq_req && ex_valid &&
                     !jump_flag && !blocked_hi;
    stall          = '0;
    flush          = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    irq_ack        = 1'b0;
    state_d        = state_q;

    // Jump and trap are mutually exclusive because the trap requires jump_flag=0.
    if (!rst) begin
      if (jump_take) begin
        flush          = jump_flush;
        redirect_valid = 1'b1;
        redirect_addr  = jump_addr;
      end else if (trap_take) begin
        flush          = jump_flush;
        redirect_valid = 1'b1;
        redirect_addr  = irq_vec;
        irq_ack        = 1'b1;
      end else begin
        stall = stall_mask;
      end
    end

    unique case (state_q)
      RUN:     if (irq_req) state_d = DRAIN;
      DRAIN: begin
        if (trap_take)     state_d = MASKED;
        else if (!irq_req) state_d = RUN;
      end
      MASKED:  if (irq_done) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      irq_epc   <= '0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (trap_take) irq_epc <= ex_pc;
      if (stall[STG_PC]) stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the RISC-V core. Generates per-stage stall and flush vectors from per-stage stall requests and the branch/jump resolution stage, and forwards the redirect to the PC stage. Adds an interrupt-entry state machine that drains in-flight hazards, squashes the instruction in the jump stage and redirects to the trap vector. Also keeps a stall-cycle performance counter. Sits between the decode/execute/memory stages and the PC/IF stage, replacing the fixed 6-stage controller.

## Interface
- STAGES, 6, number of pipeline stages; index 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB
- JUMP_STAGE, 3, stage that resolves jumps/branches; 1 ≤ JUMP_STAGE < STAGES
- ADDR_W, 32, address width
- CNT_W, 32, stall counter width
- clk  in  1  clock; one clock domain, all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- stall_req  in  STAGES  stall_req[k]=1: stage k cannot advance this cycle
- jump_flag  in  1  jump/branch taken in JUMP_STAGE
- jump_addr  in  ADDR_W  jump target
- ex_valid  in  1  JUMP_STAGE holds a real instruction, not a bubble
- ex_pc  in  ADDR_W  PC of the instruction in JUMP_STAGE
- irq_req  in  1  level interrupt request
- irq_vec  in  ADDR_W  trap vector
- irq_done  in  1  one-cycle pulse from the mret path; re-enables interrupts
- stall  out  STAGES  stall[k]=1: stage k holds its registers
- flush  out  STAGES  flush[k]=1: stage k loads a bubble
- redirect_valid  out  1  PC loads redirect_addr
- redirect_addr  out  ADDR_W  new PC
- irq_ack  out  1  one-cycle pulse on trap entry
- irq_epc  out  ADDR_W  PC saved on trap entry; held until next trap
- stall_cnt  out  CNT_W  count of cycles with stall[0]=1

## Operation
- Stall vector: let h = highest k with stall_req[k]=1. stall[h:0]=1 and all higher bits 0. If no request, stall=0.
- Jump is taken only when no stall_req at index ≥ JUMP_STAGE. When taken:
  - redirect_valid=1 and redirect_addr=jump_addr.
  - flush[JUMP_STAGE:1]=1 and stall[0]=0.
  - stall_req below JUMP_STAGE is ignored because those stages are flushed.
- If the jump is blocked by an older stall, stall[JUMP_STAGE:0] follow the stall rule. The jump stage stays frozen and keeps jump_flag asserted, so the redirect fires on the first unblocked cycle.
- Interrupt FSM has three states: RUN, DRAIN, MASKED.
  - RUN → DRAIN when irq_req=1.
  - DRAIN takes the trap when all of: no stall_req at index ≥ JUMP_STAGE, jump_flag=0, ex_valid=1.
  - Trap cycle: redirect_valid=1, redirect_addr=irq_vec, flush[JUMP_STAGE:1]=1, irq_ack=1, irq_epc←ex_pc. Next state is MASKED.
  - A trap overrides any lower-index stall requests.
  - While in DRAIN, jumps are taken normally; the FSM simply waits.
  - If irq_req drops in DRAIN, return to RUN with no trap.
  - MASKED → RUN on irq_done. irq_req is ignored while MASKED.
- irq_done in RUN or DRAIN is ignored.
- stall_cnt increments on every cycle with stall[0]=1 and wraps modulo 2^CNT_W.

## Timing
- stall, flush, redirect_valid, redirect_addr and irq_ack are combinational from the inputs and the current FSM state, with zero-cycle latency.
- FSM state, irq_epc and stall_cnt are registered.
- Reset values: state=RUN, irq_epc=0, stall_cnt=0.
- While rst=1, all combinational outputs are forced to 0.
- Minimum irq_req-to-irq_ack latency is 1 cycle: irq_req rises in cycle t, DRAIN is entered at t+1, and irq_ack can fire in t+1.
- Only one redirect source is active per cycle. A trap is never taken in a cycle with jump_flag=1.
- Reset asserted in DRAIN or MASKED returns to RUN and discards the pending or masked state.

## Structure
- Shared package cpu_pkg holds:
  - stage index constants (STG_PC, STG_IF, STG_ID, STG_EX, STG_MEM, STG_WB)
  - the irq_state_t enum (RUN, DRAIN, MASKED)
- One sub-module, stall_mask_gen: priority encoder turning stall_req into the thermometer stall mask. Purely combinational and parametrised on STAGES.
- FSM, counter and redirect muxing live in the top module.

## Test plan
- Stall priority: stall_req=6'b000100 → stall=6'b000111. Then stall_req=6'b010100 → stall=6'b011111. stall_cnt advances by 2.
- Unblocked jump: jump_flag=1, jump_addr=0x100, stall_req=0 → redirect_valid=1, redirect_addr=0x100, flush=6'b001110, stall=0.
- Blocked jump: jump_flag=1 with stall_req[4]=1 for 3 cycles → stall=6'b011111 and redirect_valid=0 for those 3 cycles. Redirect to jump_addr fires in the cycle after stall_req[4] drops.
- Interrupt entry: irq_req=1, ex_valid=1, ex_pc=0x40, irq_vec=0x8 → next cycle irq_ack=1, redirect_addr=0x8, flush=6'b001110, then irq_epc=0x40 and state MASKED. A second irq_req gets no ack until an irq_done pulse.
- IRQ vs jump: irq_req=1 and jump_flag=1 in the same cycle → jump redirect first. Trap is taken only on the next cycle with ex_valid=1.
- Reset mid-DRAIN: rst=1 for one cycle → state RUN, stall_cnt=0, no irq_ack.
